// File: rtl/ysyx_23060332_idu_pipe_if.sv
// IFU/regfile/EXU-facing bus of the decode stage.
// The slave modport is the decode stage itself; master is its environment.
interface ysyx_23060332_idu_pipe_if #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          inst_i;
  logic [XLEN-1:0]      pc_i;
  logic                 flush;
  logic [RF_ADDR_W-1:0] raddr1;
  logic [RF_ADDR_W-1:0] raddr2;
  logic [XLEN-1:0]      rdata1;
  logic [XLEN-1:0]      rdata2;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      op1;
  logic [XLEN-1:0]      op2;
  logic [XLEN-1:0]      op1_jump;
  logic [XLEN-1:0]      op2_jump;
  logic [XLEN-1:0]      store_data;
  logic                 reg_wen;
  logic [RF_ADDR_W-1:0] waddr;
  logic [31:0]          inst_o;
  logic [XLEN-1:0]      pc_o;
  logic                 illegal;
  logic                 ebreak;

  modport slave (
    input  in_valid, inst_i, pc_i, flush, rdata1, rdata2, out_ready,
    output in_ready, raddr1, raddr2, out_valid, op1, op2, op1_jump, op2_jump,
           store_data, reg_wen, waddr, inst_o, pc_o, illegal, ebreak
  );

  modport master (
    output in_valid, inst_i, pc_i, flush, rdata1, rdata2, out_ready,
    input  in_ready, raddr1, raddr2, out_valid, op1, op2, op1_jump, op2_jump,
           store_data, reg_wen, waddr, inst_o, pc_o, illegal, ebreak
  );
endinterface

// File: rtl/ysyx_23060332_idu_pipe.sv
// RV32I/RV32E decode stage: combinational decode + regfile read, one registered
// output slot with valid/ready on both sides, flush, illegal and EBREAK flags.
module ysyx_23060332_idu_pipe #(
  parameter int          XLEN      = 32,
  parameter int          RF_ADDR_W = 5,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_23060332_idu_pipe_if.slave bus
);
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_MISC   = 7'b000_1111;
  localparam logic [6:0] OPC_OPIMM  = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

  typedef struct packed {
    logic [31:0]          inst;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      op1;
    logic [XLEN-1:0]      op2;
    logic [XLEN-1:0]      op1_jump;
    logic [XLEN-1:0]      op2_jump;
    logic [XLEN-1:0]      store_data;
    logic                 reg_wen;
    logic [RF_ADDR_W-1:0] waddr;
    logic                 illegal;
    logic                 ebreak;
  } slot_t;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // Register index outside the implemented file (only possible for RV32E).
  function automatic logic idx_bad(input logic [4:0] idx);
    return {1'b0, idx} >= 6'(1 << RF_ADDR_W);
  endfunction

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign inst   = bus.inst_i;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];
  assign imm_i  = sext({{20{inst[31]}}, inst[31:20]});
  assign imm_s  = sext({{20{inst[31]}}, inst[31:25], inst[11:7]});
  assign imm_b  = sext({{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
  assign imm_u  = sext({inst[31:12], 12'b0});
  assign imm_j  = sext({{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});

  slot_t dec;
  logic  use_rs1;
  logic  use_rs2;
  logic  use_rd;
  logic  legal;
  logic  bad_idx;

  always_comb begin
    dec      = '0;
    dec.inst = inst;
    dec.pc   = bus.pc_i;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rd   = 1'b0;
    legal    = 1'b0;
    case (opcode)
      OPC_OPIMM: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        dec.op1 = bus.rdata1;
        dec.op2 = imm_i;
        case (funct3)
          3'b001:  legal = (funct7 == 7'h00);
          3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          default: legal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        dec.op1 = bus.rdata1;
        dec.op2 = imm_i;
        legal   = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OPC_STORE: begin
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        dec.op1        = bus.rdata1;
        dec.op2        = imm_s;
        dec.store_data = bus.rdata2;
        legal          = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      end
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        dec.op1 = bus.rdata1;
        dec.op2 = bus.rdata2;
        legal   = (funct7 == 7'h00) ||
                  ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_BRANCH: begin
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        dec.op1      = bus.rdata1;
        dec.op2      = bus.rdata2;
        dec.op1_jump = bus.pc_i;
        dec.op2_jump = imm_b;
        legal        = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_LUI: begin
        use_rd  = 1'b1;
        dec.op1 = imm_u;
        legal   = 1'b1;
      end
      OPC_AUIPC: begin
        use_rd  = 1'b1;
        dec.op1 = bus.pc_i;
        dec.op2 = imm_u;
        legal   = 1'b1;
      end
      OPC_JAL: begin
        use_rd       = 1'b1;
        dec.op1      = bus.pc_i;
        dec.op2      = XLEN'(4);
        dec.op1_jump = bus.pc_i;
        dec.op2_jump = imm_j;
        legal        = 1'b1;
      end
      OPC_JALR: begin
        use_rs1      = 1'b1;
        use_rd       = 1'b1;
        dec.op1      = bus.pc_i;
        dec.op2      = XLEN'(4);
        dec.op1_jump = bus.rdata1;
        dec.op2_jump = imm_i;
        legal        = (funct3 == 3'b000);
      end
      OPC_MISC:   legal = (funct3 == 3'b000);
      OPC_SYSTEM: begin
        // Only ECALL and EBREAK exist in the base ISA; CSR forms are rejected.
        dec.ebreak = (inst == 32'h0010_0073);
        legal      = (inst == 32'h0010_0073) || (inst == 32'h0000_0073);
      end
      default: legal = 1'b0;
    endcase

    dec.reg_wen = use_rd;
    dec.waddr   = use_rd ? rd[RF_ADDR_W-1:0] : '0;
    bad_idx     = (use_rs1 && idx_bad(rs1)) || (use_rs2 && idx_bad(rs2)) ||
                  (use_rd && idx_bad(rd));

    // The configured no-op always decodes as a clean write to x0 with zero operands.
    if (inst == NOP_INST) begin
      legal          = 1'b1;
      bad_idx        = 1'b0;
      dec.op1        = '0;
      dec.op2        = '0;
      dec.op1_jump   = '0;
      dec.op2_jump   = '0;
      dec.store_data = '0;
      dec.reg_wen    = 1'b1;
      dec.waddr      = '0;
      dec.ebreak     = 1'b0;
    end

    if (!legal || bad_idx) begin
      dec.op1        = '0;
      dec.op2        = '0;
      dec.op1_jump   = '0;
      dec.op2_jump   = '0;
      dec.store_data = '0;
      dec.reg_wen    = 1'b0;
      dec.waddr      = '0;
      dec.ebreak     = 1'b0;
      dec.illegal    = 1'b1;
    end
  end

  assign bus.raddr1 = use_rs1 ? rs1[RF_ADDR_W-1:0] : '0;
  assign bus.raddr2 = use_rs2 ? rs2[RF_ADDR_W-1:0] : '0;

  logic  out_valid_q;
  logic  out_valid_d;
  slot_t slot_q;
  slot_t slot_d;
  logic  in_ready;
  logic  accept;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    out_valid_d = out_valid_q;
    slot_d      = slot_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      slot_d      = dec;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      slot_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      slot_q      <= slot_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.op1        = slot_q.op1;
  assign bus.op2        = slot_q.op2;
  assign bus.op1_jump   = slot_q.op1_jump;
  assign bus.op2_jump   = slot_q.op2_jump;
  assign bus.store_data = slot_q.store_data;
  assign bus.reg_wen    = slot_q.reg_wen;
  assign bus.waddr      = slot_q.waddr;
  assign bus.inst_o     = slot_q.inst;
  assign bus.pc_o       = slot_q.pc;
  assign bus.illegal    = slot_q.illegal;
  assign bus.ebreak     = slot_q.ebreak;
endmodule

// File: tb/tb_ysyx_23060332_idu_pipe.sv
// Directed-vector bench for the decode stage: RV32I instance plus an RV32E
// instance for register-range checks.
module tb_ysyx_23060332_idu_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060332_idu_pipe_if #(.XLEN(32), .RF_ADDR_W(5)) bus ();
  ysyx_23060332_idu_pipe_if #(.XLEN(32), .RF_ADDR_W(4)) bus_e ();

  ysyx_23060332_idu_pipe #(.XLEN(32), .RF_ADDR_W(5), .NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  ysyx_23060332_idu_pipe #(.XLEN(32), .RF_ADDR_W(4), .NOP_INST(32'h0000_0013)) dut_e (
    .clk(clk), .rst(rst), .bus(bus_e)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] j1;
    logic [31:0] j2;
    logic [31:0] sd;
    logic        wen;
    logic [4:0]  wa;
    logic        ill;
    logic        ebk;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  logic [31:0] e_inst[3];
  logic        e_ill[3];
  logic        e_wen[3];

  initial begin
    //            inst          pc            rd1           rd2           ra1   ra2   op1           op2           j1            j2            sd            wen   wa    ill   ebk
    vecs[0]  = '{32'hFFF10093, 32'h0,        32'h5,        32'h0,        5'd2, 5'd0, 32'h5,        32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        1'b1, 5'd1, 1'b0, 1'b0};
    vecs[1]  = '{32'h123452B7, 32'h0,        32'h0,        32'h0,        5'd0, 5'd0, 32'h12345000, 32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 5'd5, 1'b0, 1'b0};
    vecs[2]  = '{32'h80000197, 32'h1000,     32'h0,        32'h0,        5'd0, 5'd0, 32'h1000,     32'h80000000, 32'h0,        32'h0,        32'h0,        1'b1, 5'd3, 1'b0, 1'b0};
    vecs[3]  = '{32'h002081B3, 32'h0,        32'h7,        32'h9,        5'd1, 5'd2, 32'h7,        32'h9,        32'h0,        32'h0,        32'h0,        1'b1, 5'd3, 1'b0, 1'b0};
    vecs[4]  = '{32'h402081B3, 32'h0,        32'h3,        32'h4,        5'd1, 5'd2, 32'h3,        32'h4,        32'h0,        32'h0,        32'h0,        1'b1, 5'd3, 1'b0, 1'b0};
    vecs[5]  = '{32'h0020A423, 32'h0,        32'h100,      32'hDEADBEEF, 5'd1, 5'd2, 32'h100,      32'h8,        32'h0,        32'h0,        32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 1'b0};
    vecs[6]  = '{32'hFE20AE23, 32'h0,        32'h200,      32'h55,       5'd1, 5'd2, 32'h200,      32'hFFFFFFFC, 32'h0,        32'h0,        32'h55,       1'b0, 5'd0, 1'b0, 1'b0};
    vecs[7]  = '{32'hFE000EE3, 32'h80000010, 32'h0,        32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'h80000010, 32'hFFFFFFFC, 32'h0,        1'b0, 5'd0, 1'b0, 1'b0};
    vecs[8]  = '{32'h00209463, 32'h100,      32'h1,        32'h2,        5'd1, 5'd2, 32'h1,        32'h2,        32'h100,      32'h8,        32'h0,        1'b0, 5'd0, 1'b0, 1'b0};
    vecs[9]  = '{32'hFFFFF0EF, 32'h2000,     32'h0,        32'h0,        5'd0, 5'd0, 32'h2000,     32'h4,        32'h2000,     32'hFFFFFFFE, 32'h0,        1'b1, 5'd1, 1'b0, 1'b0};
    vecs[10] = '{32'h00C280E7, 32'h3000,     32'h4000,     32'h0,        5'd5, 5'd0, 32'h3000,     32'h4,        32'h4000,     32'hC,        32'h0,        1'b1, 5'd1, 1'b0, 1'b0};
    vecs[11] = '{32'h00100073, 32'h0,        32'h0,        32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 5'd0, 1'b0, 1'b1};
    vecs[12] = '{32'hFFFFFFFF, 32'h0,        32'h11,       32'h22,       5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 5'd0, 1'b1, 1'b0};
    vecs[13] = '{32'h40311093, 32'h0,        32'h80,       32'h0,        5'd2, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 5'd0, 1'b1, 1'b0};
    vecs[14] = '{32'h40315093, 32'h0,        32'h80,       32'h0,        5'd2, 5'd0, 32'h80,       32'h403,      32'h0,        32'h0,        32'h0,        1'b1, 5'd1, 1'b0, 1'b0};
    vecs[15] = '{32'h00000013, 32'h0,        32'h0,        32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b1, 5'd0, 1'b0, 1'b0};
    vecs[16] = '{32'hFF81A203, 32'h0,        32'h1000,     32'h0,        5'd3, 5'd0, 32'h1000,     32'hFFFFFFF8, 32'h0,        32'h0,        32'h0,        1'b1, 5'd4, 1'b0, 1'b0};
    vecs[17] = '{32'h0001B203, 32'h0,        32'h1000,     32'h0,        5'd3, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 5'd0, 1'b1, 1'b0};
    vecs[18] = '{32'h402091B3, 32'h0,        32'h3,        32'h4,        5'd1, 5'd2, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 5'd0, 1'b1, 1'b0};

    e_inst[0] = 32'h000880B3; e_ill[0] = 1'b1; e_wen[0] = 1'b0;  // rs1 = x17
    e_inst[1] = 32'h003100B3; e_ill[1] = 1'b0; e_wen[1] = 1'b1;  // add x1,x2,x3
    e_inst[2] = 32'h002088B3; e_ill[2] = 1'b1; e_wen[2] = 1'b0;  // rd = x17

    bus.in_valid = 1'b0; bus.inst_i = '0; bus.pc_i = '0; bus.flush = 1'b0;
    bus.rdata1 = '0; bus.rdata2 = '0; bus.out_ready = 1'b1;
    bus_e.in_valid = 1'b0; bus_e.inst_i = '0; bus_e.pc_i = '0; bus_e.flush = 1'b0;
    bus_e.rdata1 = '0; bus_e.rdata2 = '0; bus_e.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst.out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst.reg_wen", 32'(bus.reg_wen), 32'h0);
    chk("rst.waddr", 32'(bus.waddr), 32'h0);
    chk("rst.illegal", 32'(bus.illegal), 32'h0);
    chk("rst.ebreak", 32'(bus.ebreak), 32'h0);
    chk("rst.op1", bus.op1, 32'h0);
    chk("rst_e.out_valid", 32'(bus_e.out_valid), 32'h0);
    rst = 1'b0;

    // Back-to-back decode table, out_ready held high
    for (int i = 0; i < NV; i++) begin
      bus.in_valid = 1'b1;
      bus.inst_i   = vecs[i].inst;
      bus.pc_i     = vecs[i].pc;
      bus.rdata1   = vecs[i].rd1;
      bus.rdata2   = vecs[i].rd2;
      bus.out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d.raddr1", i), 32'(bus.raddr1), 32'(vecs[i].ra1));
      chk($sformatf("v%0d.raddr2", i), 32'(bus.raddr2), 32'(vecs[i].ra2));
      chk($sformatf("v%0d.in_ready", i), 32'(bus.in_ready), 32'h1);
      tick();
      chk($sformatf("v%0d.out_valid", i), 32'(bus.out_valid), 32'h1);
      chk($sformatf("v%0d.op1", i), bus.op1, vecs[i].op1);
      chk($sformatf("v%0d.op2", i), bus.op2, vecs[i].op2);
      chk($sformatf("v%0d.op1_jump", i), bus.op1_jump, vecs[i].j1);
      chk($sformatf("v%0d.op2_jump", i), bus.op2_jump, vecs[i].j2);
      chk($sformatf("v%0d.store_data", i), bus.store_data, vecs[i].sd);
      chk($sformatf("v%0d.reg_wen", i), 32'(bus.reg_wen), 32'(vecs[i].wen));
      chk($sformatf("v%0d.waddr", i), 32'(bus.waddr), 32'(vecs[i].wa));
      chk($sformatf("v%0d.illegal", i), 32'(bus.illegal), 32'(vecs[i].ill));
      chk($sformatf("v%0d.ebreak", i), 32'(bus.ebreak), 32'(vecs[i].ebk));
      chk($sformatf("v%0d.inst_o", i), bus.inst_o, vecs[i].inst);
      chk($sformatf("v%0d.pc_o", i), bus.pc_o, vecs[i].pc);
      $display("vec %0d inst=%08h op1=%08h op2=%08h", i, vecs[i].inst, bus.op1, bus.op2);
    end

    // Drain with nothing incoming
    bus.in_valid = 1'b0;
    tick();
    chk("drain.out_valid", 32'(bus.out_valid), 32'h0);
    chk("drain.inst_o_held", bus.inst_o, 32'h402091B3);

    // Backpressure: A accepted into empty slot, B waits three stalled cycles
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.inst_i    = 32'hFFF10093;
    bus.rdata1    = 32'h5;
    tick();
    chk("bp.A_valid", 32'(bus.out_valid), 32'h1);
    bus.inst_i = 32'h123452B7;
    bus.rdata1 = 32'h99;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp.stall%0d.in_ready", c), 32'(bus.in_ready), 32'h0);
      tick();
      chk($sformatf("bp.stall%0d.out_valid", c), 32'(bus.out_valid), 32'h1);
      chk($sformatf("bp.stall%0d.waddr", c), 32'(bus.waddr), 32'h1);
      chk($sformatf("bp.stall%0d.op1", c), bus.op1, 32'h5);
      $display("stall cycle %0d waddr=%0d op1=%08h", c, bus.waddr, bus.op1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("bp.B_valid", 32'(bus.out_valid), 32'h1);
    chk("bp.B_waddr", 32'(bus.waddr), 32'h5);
    chk("bp.B_op1", bus.op1, 32'h12345000);
    bus.in_valid = 1'b0;
    tick();
    chk("bp.B_drained", 32'(bus.out_valid), 32'h0);

    // Flush while the slot is valid and an accept is offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.inst_i    = 32'hFFF10093;
    bus.rdata1    = 32'h5;
    tick();
    chk("fl.A_valid", 32'(bus.out_valid), 32'h1);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    bus.inst_i    = 32'h123452B7;
    tick();
    chk("fl.out_valid", 32'(bus.out_valid), 32'h0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("fl.dropped%0d", c), 32'(bus.out_valid), 32'h0);
      $display("post-flush cycle %0d out_valid=%0d", c, bus.out_valid);
    end

    // RV32E register-range checks on the 16-register instance
    for (int i = 0; i < 3; i++) begin
      bus_e.in_valid = 1'b1;
      bus_e.inst_i   = e_inst[i];
      bus_e.rdata1   = 32'h2;
      bus_e.rdata2   = 32'h3;
      tick();
      chk($sformatf("e%0d.out_valid", i), 32'(bus_e.out_valid), 32'h1);
      chk($sformatf("e%0d.illegal", i), 32'(bus_e.illegal), 32'(e_ill[i]));
      chk($sformatf("e%0d.reg_wen", i), 32'(bus_e.reg_wen), 32'(e_wen[i]));
      chk($sformatf("e%0d.op1", i), bus_e.op1, e_ill[i] ? 32'h0 : 32'h2);
      chk($sformatf("e%0d.waddr", i), 32'(bus_e.waddr), e_ill[i] ? 32'h0 : 32'h1);
      $display("rv32e inst=%08h illegal=%0d", e_inst[i], bus_e.illegal);
    end
    bus_e.in_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/ysyx_23060332_idu_pipe.md
Name: ysyx_23060332_idu_pipe

Overview:
Pipelined instruction-decode stage sitting between the IFU and the EXU. It decodes RV32I/RV32E base-integer instructions into EXU operands and reads the register file combinationally. Decoded results are registered in one output slot, with a valid/ready handshake on both sides. It adds a flush input and reports illegal instructions and EBREAK as registered flags alongside the decoded instruction.

Parameters:
XLEN, 32, datapath width for operands, PC and immediates; immediates are sign-extended to XLEN.
RF_ADDR_W, 5, register-address width; 5 = RV32I (32 regs), 4 = RV32E (16 regs).
NOP_INST, 32'h00000013, encoding treated as a legal no-op.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  IFU presents inst_i/pc_i
in_ready  out  1  stage can accept this cycle
inst_i  in  32  instruction word
pc_i  in  XLEN  instruction address
flush  in  1  discard held and incoming instruction (redirect)
raddr1  out  RF_ADDR_W  regfile read address 1 (combinational from inst_i)
raddr2  out  RF_ADDR_W  regfile read address 2 (combinational from inst_i)
rdata1  in  XLEN  regfile read data 1
rdata2  in  XLEN  regfile read data 2
out_valid  out  1  output slot holds a decoded instruction
out_ready  in  1  EXU accepts the slot
op1, op2  out  XLEN  ALU operands
op1_jump, op2_jump  out  XLEN  branch/jump target operands
store_data  out  XLEN  rs2 value for stores
reg_wen  out  1  destination write enable
waddr  out  RF_ADDR_W  destination register
inst_o  out  32  registered instruction
pc_o  out  XLEN  registered PC
illegal  out  1  registered illegal-instruction flag
ebreak  out  1  registered EBREAK flag

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: out_valid=0; all registered outputs = 0 (waddr=0, reg_wen=0, illegal=0, ebreak=0).
- in_ready = !out_valid || out_ready. It is combinational and does not depend on in_valid.
- Accept: in_valid && in_ready && !flush. On that edge, register all decoded fields and set out_valid=1.
- Drain: out_valid && out_ready with no accept. On that edge, set out_valid=0 and hold the data fields.
- Simultaneous drain and accept: the new instruction replaces the old one; out_valid stays 1. This gives zero-bubble throughput of 1 instr/cycle.
- Stall: out_valid && !out_ready. All outputs are held stable; in_ready=0.
- flush: has priority over accept and hold. Next cycle out_valid=0; the incoming instruction is dropped. The data fields may hold stale values.
- Latency: 1 cycle from accept to out_valid.
- raddr1/raddr2: driven from inst_i every cycle whether or not in_valid is set. They are 0 for formats that do not use the corresponding source register.
- Decode, all immediates sign-extended from inst[31] to XLEN:
  - OP-IMM (ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI): op1=rs1 value, op2=I-imm, wen=1.
  - LOAD (LB/LH/LW/LBU/LHU): op1=rs1 value, op2=I-imm, wen=1.
  - STORE (SB/SH/SW): op1=rs1 value, op2=S-imm, store_data=rs2 value, wen=0.
  - OP (all 10 R-type): op1=rs1 value, op2=rs2 value, wen=1.
  - BRANCH (6 types): op1/op2=rs1/rs2 values, op1_jump=pc, op2_jump=B-imm.
  - LUI: op1={imm20,12'b0} (sign-extended), op2=0.
  - AUIPC: op1=pc, op2=U-imm.
  - JAL: op1=pc, op2=4, op1_jump=pc, op2_jump=J-imm.
  - JALR: op1=pc, op2=4, op1_jump=rs1 value, op2_jump=I-imm.
  - SYSTEM: 0x00100073 sets ebreak=1.
- Illegal instructions: unknown opcode, undefined funct3, or bad funct7 on OP/shift-immediate all set illegal=1. In that case reg_wen is forced to 0 and all operands to 0.
- RV32E (RF_ADDR_W=4): any used rs1/rs2/rd index ≥16 sets illegal=1 and forces reg_wen=0.
- rd=0: reg_wen follows decode (writes to x0 are dropped by the regfile), waddr=0.
- NOP_INST decodes as a normal ADDI x0,x0,0.

Test Plan:
- Reset then pass-through: rst for 2 cycles → out_valid=0, in_ready=1. Then inst 0xFFF10093 (addi x1,x2,-1) with rdata1=5 → next cycle out_valid=1, op1=5, op2=0xFFFFFFFF, waddr=1, reg_wen=1.
- Back-to-back with out_ready=1: lui x5,0x12345 (0x123452B7) followed by addi → consecutive out_valid cycles. First instruction: op1=0x12345000, waddr=5. in_ready stays 1 throughout.
- Backpressure: out_ready=0 for 3 cycles with a second in_valid pending → in_ready=0 and outputs held. Releasing out_ready → second instruction appears on the next cycle with nothing lost or duplicated.
- Flush: flush=1 in the same cycle as an in_valid accept while the slot is valid → next cycle out_valid=0. The dropped instruction never appears.
- Exceptions: 0x00100073 → ebreak=1, illegal=0. 0xFFFFFFFF → illegal=1, reg_wen=0. With RF_ADDR_W=4, 0x000880B3 (add x1,x17,x0) → illegal=1.
- Branch/jump targets: beq at pc=0x80000010 with inst 0xFE000EE3 → op1_jump=0x80000010, op2_jump=0xFFFFFFFC. JAL with an all-ones J-imm → op2_jump sign-extended to XLEN.
